// File: rtl/riscv_trace_buffer.sv
// Capture buffer for RISC-V core trace events (register writebacks, data memory accesses).
// Each event is timestamped, queued in a first-word-fall-through FIFO, and counted when dropped.
module riscv_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int TS_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     reg_write_sig,
  input  logic [4:0]               reg_num,
  input  logic [31:0]              reg_data,
  input  logic                     wr,
  input  logic                     reade,
  input  logic [8:0]               addr,
  input  logic [31:0]              wr_data,
  input  logic [31:0]              rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_kind,
  output logic [8:0]               out_index,
  output logic [31:0]              out_data,
  output logic [TS_W-1:0]          out_time,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [7:0]               overflow_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 + 9 + 32 + TS_W;

  logic [TS_W-1:0] ts;
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [EW-1:0]   mem [DEPTH];

  logic            reg_ev;
  logic            mem_ev;
  logic [EW-1:0]   reg_entry;
  logic [EW-1:0]   mem_entry;
  logic [EW-1:0]   first_entry;
  logic [EW-1:0]   head;
  logic [CW-1:0]   free_space;
  logic            push_first;
  logic            push_second;
  logic            pop;
  logic [1:0]      n_push;
  logic [1:0]      n_drop;
  logic [8:0]      ovf_sum;

  assign reg_ev = enable & reg_write_sig;
  assign mem_ev = enable & (wr ^ reade);

  // Entry layout: {kind, index, data, time}
  assign reg_entry   = {2'd0, 4'd0, reg_num, reg_data, ts};
  assign mem_entry   = {(wr ? 2'd1 : 2'd2), addr, (wr ? wr_data : rd_data), ts};
  assign first_entry = reg_ev ? reg_entry : mem_entry;

  // Space is judged from the start-of-cycle count; a concurrent pop does not help.
  assign free_space = CW'(DEPTH) - count;

  always_comb begin
    push_first  = 1'b0;
    push_second = 1'b0;
    n_drop      = 2'd0;
    if (reg_ev || mem_ev) begin
      if (free_space >= CW'(2)) begin
        push_first  = 1'b1;
        push_second = reg_ev & mem_ev;
      end else if (free_space == CW'(1)) begin
        push_first = 1'b1;
        n_drop     = {1'b0, reg_ev & mem_ev};
      end else begin
        n_drop = {1'b0, reg_ev} + {1'b0, mem_ev};
      end
    end
  end

  assign n_push  = {1'b0, push_first} + {1'b0, push_second};
  assign pop     = out_valid & out_ready;
  assign ovf_sum = {1'b0, overflow_cnt} + {7'd0, n_drop};

  always_ff @(posedge clk) begin
    if (reset) begin
      ts           <= '0;
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      overflow_cnt <= '0;
    end else begin
      ts           <= ts + TS_W'(1);
      wptr         <= wptr + AW'(n_push);
      if (pop) rptr <= rptr + AW'(1);
      count        <= count + CW'(n_push) - CW'(pop);
      overflow_cnt <= (ovf_sum > 9'd255) ? 8'hFF : ovf_sum[7:0];
    end
  end

  // Storage needs no reset; stale slots are never visible because out fields are masked.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (push_first)  mem[wptr]            <= first_entry;
      if (push_second) mem[wptr + AW'(1)]   <= mem_entry;
    end
  end

  assign head      = mem[rptr];
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign out_valid = !empty;

  assign {out_kind, out_index, out_data, out_time} = out_valid ? head : '0;

endmodule

// File: doc/riscv_trace_buffer.md
RISCV_TRACE_BUFFER -- requirements
Module: riscv_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, at least 4).
REQ-002 SHALL have parameter TS_W, default 16, timestamp width.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port enable, input, 1, capture enable.
REQ-006 SHALL have port reg_write_sig, input, 1, core register-writeback strobe.
REQ-007 SHALL have port reg_num, input, 5, written register index.
REQ-008 SHALL have port reg_data, input, 32, written register value.
REQ-009 SHALL have ports wr and reade, input, 1 each, core data-memory write and read strobes.
REQ-010 SHALL have port addr, input, 9, data-memory word address.
REQ-011 SHALL have ports wr_data and rd_data, input, 32 each, memory write and read data.
REQ-012 SHALL have port out_valid, output, 1, head entry available.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts head entry.
REQ-014 SHALL have port out_kind, output, 2, event kind: 0 = register write, 1 = memory write, 2 = memory read.
REQ-015 SHALL have ports out_index (output, 9; reg_num zero-extended or addr), out_data (output, 32) and out_time (output, TS_W).
REQ-016 SHALL have ports count (output, log2(DEPTH)+1), full (output, 1), empty (output, 1) and overflow_cnt (output, 8).

Function
REQ-017 SHALL run a free-running TS_W-bit timestamp counter: +1 every cycle, wraps to 0, independent of enable.
REQ-018 SHALL qualify a register event each cycle as enable && reg_write_sig.
REQ-019 SHALL qualify a memory event as enable && (wr XOR reade): a write when wr=1, a read when reade=1; wr=reade=1 is not an event and is not counted.
REQ-020 SHALL stamp every event with the timestamp value of its sampling cycle.
REQ-021 SHALL accept 0, 1 or 2 events per cycle; with 2, the register event occupies the lower FIFO slot and is popped first.
REQ-022 SHALL compute free space as DEPTH minus count at the start of the cycle; a pop in the same cycle does not free space for that cycle's pushes.
REQ-023 SHALL, on free space of 1 with 2 events, push only the register event, drop the memory event, and add 1 to overflow_cnt.
REQ-024 SHALL, on free space of 0, drop all events and add the number of events (1 or 2) to overflow_cnt.
REQ-025 SHALL saturate overflow_cnt at 255.
REQ-026 SHALL be first-word-fall-through: an event sampled at edge N makes out_valid=1 in the cycle after edge N, with no extra latency.
REQ-027 SHALL hold out_valid = !empty and pop exactly one entry on a cycle with out_valid && out_ready.
REQ-028 SHALL keep head fields stable while out_valid && !out_ready.
REQ-029 SHALL drive out_kind, out_index, out_data and out_time to 0 while out_valid=0.
REQ-030 SHALL update count as count + pushes - pop, with pointers wrapping modulo DEPTH; full = (count==DEPTH) and empty = (count==0).
REQ-031 SHALL apply a push and a pop in the same cycle without interfering with each other, including pop of the last entry while pushing.

Reset
REQ-032 SHALL, while reset=1 at a clock edge, clear the timestamp, pointers, count and overflow_cnt to 0, giving out_valid=0, empty=1, full=0, and all out_* fields 0.
REQ-033 SHALL ignore events sampled in any cycle with reset=1 and discard FIFO contents on reset mid-operation.
REQ-034 SHALL restart the timestamp at 0 on the first edge after reset deasserts, then increment it every cycle.

Verification
REQ-035 Verification SHALL cover: reg_write_sig=1, reg_num=5, reg_data=0x0000002A at timestamp 3, out_ready=0 -> next cycle out_valid=1, kind 0, index 5, data 0x2A, time 3, count 1.
REQ-036 Verification SHALL cover: same cycle reg_num=1/0x11 and wr=1, addr=0x040, wr_data=0xDEADBEEF -> count 2; pops return kind 0 first, then kind 1, index 0x040, both with equal time.
REQ-037 Verification SHALL cover: wr=reade=1 with reg_write_sig=0 -> no push, count and overflow_cnt unchanged.
REQ-038 Verification SHALL cover: fill to DEPTH-1, then a dual event -> register event stored, full=1, overflow_cnt=1; a further single event -> overflow_cnt=2.
REQ-039 Verification SHALL cover: full FIFO with out_ready=1 and a single event in the same cycle -> event dropped, count 15, overflow incremented; the next cycle's event is accepted.
REQ-040 Verification SHALL cover: reset=1 for one cycle with 8 entries buffered -> next cycle count 0, out_valid 0, overflow_cnt 0, then timestamp restarts at 0.
